ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal samples required to accept a new ps2c level.
REQ-002 Parameter TIMEOUT_CYC, default 100000: idle clk cycles that abort a partial frame.
REQ-003 Parameter RST_CYC, default 16: cycles rst_out is held high.
REQ-004 clk  in  1  system clock, single clock domain.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ps2d, ps2c  in  1 each  raw PS/2 data and clock, asynchronous to clk.
REQ-007 aumenta, disminuye, siguiente, anterior  out  1 each  one-cycle command pulses.
REQ-008 formato, quitar_alarma, cambiar_hora  out  1 each  one-cycle command pulses.
REQ-009 rst_out  out  1  system soft reset, held high RST_CYC cycles.
REQ-010 scan_code  out  8  last accepted frame byte; scan_valid  out  1  one-cycle strobe with it.
REQ-011 frame_err  out  1  one-cycle strobe on parity, start, stop or timeout error.

Function
REQ-012 ps2c and ps2d SHALL pass through 2-FF synchronizers before any use.
REQ-013 Filtered ps2c SHALL change only after FILTER_LEN identical synchronized samples; a falling edge of filtered ps2c is a bit event.
REQ-014 Receiver FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: bit event with ps2d=0 -> DATA, bit counter 0; bit event with ps2d=1 -> frame_err, stay IDLE.
REQ-016 DATA: each bit event shifts ps2d in LSB-first; after 8th bit -> PARITY.
REQ-017 PARITY: sampled bit SHALL make the total count of ones in data+parity odd, else error flag set; -> STOP.
REQ-018 STOP: ps2d=1 and no error -> scan_code updated, scan_valid pulsed 1 cycle later than the edge; otherwise frame_err pulsed, byte discarded; both -> IDLE.
REQ-019 Outside IDLE, TIMEOUT_CYC cycles with no bit event SHALL pulse frame_err and return to IDLE, discarding partial data.
REQ-020 Decoder: byte F0 sets break flag; byte E0 sets ext flag; any other byte is consumed and clears both flags after decoding.
REQ-021 Bytes received with break flag set SHALL produce no command (release ignored).
REQ-022 Make codes with ext=1: 75 -> aumenta, 72 -> disminuye, 74 -> siguiente, 6B -> anterior.
REQ-023 Make codes with ext=0: 2D -> rst_out start, 2B -> formato, 15 -> quitar_alarma, 21 -> cambiar_hora.
REQ-024 Unmapped codes, and arrow codes without E0, SHALL produce no pulse.
REQ-025 Command pulses SHALL assert exactly one cycle, one cycle after scan_valid; at most one command per byte.
REQ-026 Typematic repeat make codes SHALL each produce a new pulse.
REQ-027 rst_out start while already high SHALL restart the RST_CYC count.
REQ-028 rst_out SHALL NOT reset this block.

Reset
REQ-029 On reset: FSM IDLE, counters, shift register, break/ext flags cleared; filtered ps2c = 1; scan_code = 00.
REQ-030 On reset all pulse outputs, scan_valid, frame_err and rst_out SHALL be 0 immediately.
REQ-031 Reset mid-frame SHALL discard the partial frame; the next start bit begins a fresh frame.

Verification
REQ-032 Frame 0x2B, odd parity correct -> scan_valid with scan_code=2B, then formato high exactly 1 cycle.
REQ-033 Sequence E0,75 then E0,F0,75 -> one aumenta pulse only; no pulse on release.
REQ-034 Frame 0x15 with parity bit inverted -> frame_err pulse, no scan_valid, no quitar_alarma.
REQ-035 Send 4 bits of a frame then stop ps2c for TIMEOUT_CYC+10 cycles -> frame_err; following full frame 0x21 -> cambiar_hora.
REQ-036 Glitch on ps2c shorter than FILTER_LEN cycles mid-frame -> ignored, frame 0x6B still received correctly, no anterior (no E0).
REQ-037 Frame 0x2D -> rst_out high 16 cycles; assert reset mid-frame of a second byte -> all outputs 0, subsequent frame decodes normally.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver with scan-code to command-pulse decoding
module ps2_key_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int RST_CYC     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  output logic       aumenta,
  output logic       disminuye,
  output logic       siguiente,
  output logic       anterior,
  output logic       formato,
  output logic       quitar_alarma,
  output logic       cambiar_hora,
  output logic       rst_out,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(RST_CYC + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] c_sync, d_sync;
  logic c_filt, f_hit, bit_ev, d, tmo, ok, err, p_err, brk, ext, cmd, is_f0, is_e0;
  logic [FW-1:0] f_cnt;
  logic [TW-1:0] t_cnt;
  logic [RW-1:0] rst_cnt;
  logic [2:0] b_cnt;
  logic [7:0] shreg;
  assign d      = d_sync[1];
  assign f_hit  = (c_sync[1] != c_filt) && (f_cnt == FW'(FILTER_LEN - 1));
  assign bit_ev = f_hit && c_filt;
  assign tmo    = (state != IDLE) && !bit_ev && (t_cnt == TW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
      c_filt <= 1'b1;
      f_cnt  <= '0;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
      if (c_sync[1] == c_filt) f_cnt <= '0;
      else if (f_hit) begin
        c_filt <= c_sync[1];
        f_cnt  <= '0;
      end else f_cnt <= f_cnt + 1'b1;
    end
  always_comb begin
    state_n = state;
    ok      = 1'b0;
    err     = 1'b0;
    case (state)
      IDLE:   if (bit_ev) begin
                err     = d;
                state_n = d ? IDLE : DATA;
              end
      DATA:   if (bit_ev && b_cnt == 3'd7) state_n = PARITY;
      PARITY: if (bit_ev) state_n = STOP;
      STOP:   if (bit_ev) begin
                ok      = d && !p_err;
                err     = !ok;
                state_n = IDLE;
              end
      default: state_n = IDLE;
    endcase
    if (tmo) begin
      err     = 1'b1;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      b_cnt      <= '0;
      shreg      <= '0;
      p_err      <= 1'b0;
      t_cnt      <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      scan_valid <= ok;
      frame_err  <= err;
      t_cnt      <= (state == IDLE || bit_ev) ? '0 : t_cnt + 1'b1;
      if (state == IDLE) b_cnt <= '0;
      if (bit_ev && state == DATA) begin
        shreg <= {d, shreg[7:1]};
        b_cnt <= b_cnt + 1'b1;
      end
      if (bit_ev && state == PARITY) p_err <= ~^{shreg, d};
      if (ok) scan_code <= shreg;
    end
  // F0/E0 are prefixes; any other byte is a final code that consumes both flags
  assign is_f0 = scan_code == 8'hF0;
  assign is_e0 = scan_code == 8'hE0;
  assign cmd   = scan_valid && !brk && !is_f0 && !is_e0;
  assign rst_out = |rst_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      brk           <= 1'b0;
      ext           <= 1'b0;
      aumenta       <= 1'b0;
      disminuye     <= 1'b0;
      siguiente     <= 1'b0;
      anterior      <= 1'b0;
      formato       <= 1'b0;
      quitar_alarma <= 1'b0;
      cambiar_hora  <= 1'b0;
      rst_cnt       <= '0;
    end else begin
      if (scan_valid) begin
        brk <= is_f0 ? 1'b1 : is_e0 ? brk : 1'b0;
        ext <= is_e0 ? 1'b1 : is_f0 ? ext : 1'b0;
      end
      aumenta       <= cmd && ext && scan_code == 8'h75;
      disminuye     <= cmd && ext && scan_code == 8'h72;
      siguiente     <= cmd && ext && scan_code == 8'h74;
      anterior      <= cmd && ext && scan_code == 8'h6B;
      formato       <= cmd && !ext && scan_code == 8'h2B;
      quitar_alarma <= cmd && !ext && scan_code == 8'h15;
      cambiar_hora  <= cmd && !ext && scan_code == 8'h21;
      rst_cnt       <= (cmd && !ext && scan_code == 8'h2D) ? RW'(RST_CYC) :
                       rst_out ? rst_cnt - 1'b1 : rst_cnt;
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed PS/2 frames with hand-computed expected pulses
module tb_ps2_key_decoder;
  localparam int H = 10;
  localparam int TMO = 200;
  logic clk = 0, reset = 1, ps2d = 1, ps2c = 1;
  logic aumenta, disminuye, siguiente, anterior, formato, quitar_alarma, cambiar_hora, rst_out;
  logic [7:0] scan_code;
  logic scan_valid, frame_err;
  int n[10], b[10];
  int cyc = 0, sv_cyc = 0, lag = 0;
  logic [7:0] last_code = 0;
  int checks = 0, fails = 0;
  ps2_key_decoder #(.FILTER_LEN(4), .TIMEOUT_CYC(TMO), .RST_CYC(16)) dut (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c),
    .aumenta(aumenta), .disminuye(disminuye), .siguiente(siguiente), .anterior(anterior),
    .formato(formato), .quitar_alarma(quitar_alarma), .cambiar_hora(cambiar_hora),
    .rst_out(rst_out), .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    n[0] += int'(aumenta);
    n[1] += int'(disminuye);
    n[2] += int'(siguiente);
    n[3] += int'(anterior);
    n[4] += int'(formato);
    n[5] += int'(quitar_alarma);
    n[6] += int'(cambiar_hora);
    n[7] += int'(frame_err);
    n[8] += int'(scan_valid);
    n[9] += int'(rst_out);
    if (scan_valid) begin
      sv_cyc = cyc;
      last_code = scan_code;
    end
    if (aumenta | disminuye | siguiente | anterior | formato | quitar_alarma | cambiar_hora)
      lag = cyc - sv_cyc;
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int dl(input int i);
    return n[i] - b[i];
  endfunction
  task automatic ticks(input int k);
    repeat (k) @(posedge clk);
  endtask
  task automatic send_bit(input logic v, input bit glitch);
    ps2d = v;
    ps2c = 1;
    if (glitch) begin
      ticks(4);
      ps2c = 0;
      ticks(2);
      ps2c = 1;
      ticks(H - 6);
    end else ticks(H);
    ps2c = 0;
    ticks(H);
  endtask
  task automatic send_frame(input logic [7:0] code, input bit pinv, input bit glitch);
    logic [10:0] f;
    f = {1'b1, ~^code ^ pinv, code, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], glitch && i == 5);
    ps2c = 1;
    ps2d = 1;
  endtask
  task automatic frame(input logic [7:0] code);
    send_frame(code, 0, 0);
    ticks(2 * H);
  endtask
  initial begin
    #1;
    chk("reset_outs", int'({aumenta, disminuye, siguiente, anterior, formato, quitar_alarma,
                            cambiar_hora, rst_out, scan_valid, frame_err}), 0);
    chk("reset_code", int'(scan_code), 0);
    ticks(3);
    reset = 0;
    ticks(5);
    b = n;
    frame(8'h2B);
    chk("fmt_sv", dl(8), 1);
    chk("fmt_code", int'(last_code), 'h2B);
    chk("fmt_pulse", dl(4), 1);
    chk("fmt_lag", lag, 1);
    b = n;
    frame(8'hE0); frame(8'h75); frame(8'hE0); frame(8'hF0); frame(8'h75);
    chk("aum_once", dl(0), 1);
    chk("aum_sv", dl(8), 5);
    b = n;
    frame(8'hE0); frame(8'h72); frame(8'hE0); frame(8'h74); frame(8'h74);
    chk("dis", dl(1), 1);
    chk("sig_noext", dl(2), 1);
    b = n;
    send_frame(8'h15, 1, 0);
    ticks(2 * H);
    chk("par_err", dl(7), 1);
    chk("par_nosv", dl(8), 0);
    chk("par_noqa", dl(5), 0);
    b = n;
    frame(8'h15);
    chk("qa", dl(5), 1);
    b = n;
    for (int i = 0; i < 4; i++) send_bit(i != 0, 0);
    ps2c = 1;
    ticks(TMO + 10);
    chk("tmo_err", dl(7), 1);
    chk("tmo_nosv", dl(8), 0);
    frame(8'h21);
    chk("tmo_ch", dl(6), 1);
    chk("tmo_code", int'(last_code), 'h21);
    b = n;
    send_frame(8'h6B, 0, 1);
    ticks(2 * H);
    chk("glitch_sv", dl(8), 1);
    chk("glitch_code", int'(last_code), 'h6B);
    chk("glitch_noant", dl(3), 0);
    chk("glitch_noerr", dl(7), 0);
    b = n;
    frame(8'h2B); frame(8'h2B);
    chk("typematic", dl(4), 2);
    b = n;
    frame(8'h2D);
    ticks(30);
    chk("rst_len", dl(9), 16);
    chk("rst_nofmt", dl(4), 0);
    send_frame(8'h2D, 0, 0);
    ticks(2);
    chk("rst_high", int'(rst_out), 1);
    reset = 1;
    #1;
    chk("arst_rst", int'(rst_out), 0);
    chk("arst_code", int'(scan_code), 0);
    ticks(2);
    reset = 0;
    ticks(3);
    for (int i = 0; i < 4; i++) send_bit(i != 0, 0);
    ps2c = 1;
    ticks(3);
    reset = 1;
    #1;
    chk("mid_outs", int'({aumenta, disminuye, siguiente, anterior, formato, quitar_alarma,
                          cambiar_hora, rst_out, scan_valid, frame_err}), 0);
    ticks(2);
    reset = 0;
    ticks(5);
    b = n;
    frame(8'h2B);
    chk("mid_sv", dl(8), 1);
    chk("mid_code", int'(last_code), 'h2B);
    chk("mid_fmt", dl(4), 1);
    chk("mid_noerr", dl(7), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
